// File: rtl/chacha20_poly1305_pkg.sv
`default_nettype none
// ============================================================================
// Module      : chacha20_poly1305_pkg
// Description : Shared constants and FSM state encoding for the
//               ChaCha20-Poly1305 tag verifier.
//               TAG_WORDS   - number of 32-bit words in a 128-bit tag
//               IDX_W       - width of a tag word index
//               IDX_LAST    - index of the final tag word
//               state_t     - verifier FSM states
// Revision    : 1.0 - initial release
// ============================================================================
package chacha20_poly1305_pkg;

    localparam int TAG_WORDS = 4;
    localparam int WORD_W    = 32;
    localparam int IDX_W     = $clog2(TAG_WORDS);

    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(TAG_WORDS - 1);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_LOAD    = 2'd1,
        ST_COMPARE = 2'd2,
        ST_DONE    = 2'd3
    } state_t;

endpackage : chacha20_poly1305_pkg
`default_nettype wire

// File: rtl/chacha20_poly1305_tag_verifier.sv
`default_nettype none
// ============================================================================
// Module      : chacha20_poly1305_tag_verifier
// Description : Constant-time comparison of a computed Poly1305 tag against
//               an expected tag loaded word by word. The comparison always
//               takes four cycles regardless of where the tags differ.
// Ports       : clk            - clock, rising-edge active
//               reset_n        - asynchronous active-low reset
//               init           - start a new verification (wins over loads)
//               exp_we         - expected-tag word write enable
//               exp_addr       - expected-tag word index (word i = bits 32i+31:32i)
//               exp_data       - expected-tag word data
//               calc_tag_valid - one-cycle strobe qualifying calc_tag
//               calc_tag       - computed 128-bit tag
//               ready          - high while idle
//               done           - one-cycle pulse at the end of a comparison
//               tag_correct    - result of the last completed comparison
//               fail_count     - saturating mismatch count since reset
// Revision    : 1.0 - initial release
// ============================================================================
module chacha20_poly1305_tag_verifier
    import chacha20_poly1305_pkg::*;
#(
    parameter int FAIL_CNT_WIDTH = 8
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      init,
    input  logic                      exp_we,
    input  logic [1:0]                exp_addr,
    input  logic [31:0]               exp_data,
    input  logic                      calc_tag_valid,
    input  logic [127:0]              calc_tag,
    output logic                      ready,
    output logic                      done,
    output logic                      tag_correct,
    output logic [FAIL_CNT_WIDTH-1:0] fail_count
);

    state_t                                r_state;
    state_t                                w_next;
    logic [TAG_WORDS-1:0][WORD_W-1:0]      r_exp;
    logic [TAG_WORDS-1:0][WORD_W-1:0]      r_calc;
    logic [TAG_WORDS-1:0]                  r_mask;
    logic                                  r_captured;
    logic [WORD_W-1:0]                     r_diff;
    logic [IDX_W-1:0]                      r_idx;
    logic                                  r_tag_correct;
    logic [FAIL_CNT_WIDTH-1:0]             r_fail_count;
    logic [WORD_W-1:0]                     w_diff_next;

    // Differences are OR-accumulated so the outcome depends only on whether
    // any bit differed, never on which word differed first.
    assign w_diff_next = r_diff | (r_exp[r_idx] ^ r_calc[r_idx]);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        ready  = 1'b0;
        done   = 1'b0;
        case (r_state)
            ST_IDLE:    ready = 1'b1;
            ST_LOAD:    if (&r_mask && r_captured) w_next = ST_COMPARE;
            ST_COMPARE: if (r_idx == IDX_LAST) w_next = ST_DONE;
            ST_DONE: begin
                done   = 1'b1;
                w_next = ST_IDLE;
            end
            default:    w_next = ST_IDLE;
        endcase
        if (init) begin
            w_next = ST_LOAD;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_exp         <= '0;
            r_calc        <= '0;
            r_mask        <= '0;
            r_captured    <= 1'b0;
            r_diff        <= '0;
            r_idx         <= '0;
            r_tag_correct <= 1'b0;
            r_fail_count  <= '0;
        end else if (init) begin
            // Any load or capture arriving alongside init is dropped.
            r_mask        <= '0;
            r_captured    <= 1'b0;
            r_diff        <= '0;
            r_idx         <= '0;
            r_tag_correct <= 1'b0;
        end else begin
            case (r_state)
                ST_LOAD: begin
                    r_idx  <= '0;
                    r_diff <= '0;
                    if (exp_we) begin
                        r_exp[exp_addr]  <= exp_data;
                        r_mask[exp_addr] <= 1'b1;
                    end
                    if (calc_tag_valid) begin
                        r_calc     <= calc_tag;
                        r_captured <= 1'b1;
                    end
                end
                ST_COMPARE: begin
                    r_diff <= w_diff_next;
                    r_idx  <= r_idx + 1'b1;
                    // Result is committed on the edge into DONE so it is
                    // already valid while done is high.
                    if (r_idx == IDX_LAST) begin
                        r_tag_correct <= (w_diff_next == '0);
                        if ((w_diff_next != '0) && !(&r_fail_count)) begin
                            r_fail_count <= r_fail_count + 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign tag_correct = r_tag_correct;
    assign fail_count  = r_fail_count;

endmodule : chacha20_poly1305_tag_verifier
`default_nettype wire

// File: doc/chacha20_poly1305_tag_verifier.md
CHACHA20_POLY1305_TAG_VERIFIER -- requirements
Module: chacha20_poly1305_tag_verifier

Interface
REQ-001 The block SHALL have parameter FAIL_CNT_WIDTH, default 8, giving the width of the saturating mismatch counter.
REQ-002 The block SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port reset_n  input  1  reset, asynchronous and active-low.
REQ-004 The block SHALL have port init  input  1  start a new verification; clears the expected-tag load mask and the result.
REQ-005 The block SHALL have port exp_we  input  1  write enable for one expected-tag word.
REQ-006 The block SHALL have port exp_addr  input  2  expected-tag word index; word i maps to tag bits [32i+31:32i].
REQ-007 The block SHALL have port exp_data  input  32  expected-tag word data.
REQ-008 The block SHALL have port calc_tag_valid  input  1  single-cycle strobe marking the computed Poly1305 tag as valid.
REQ-009 The block SHALL have port calc_tag  input  128  computed Poly1305 tag from the AEAD core.
REQ-010 The block SHALL have port ready  output  1  high in IDLE only.
REQ-011 The block SHALL have port done  output  1  one-cycle pulse when the comparison completes.
REQ-012 The block SHALL have port tag_correct  output  1  result of the last completed comparison; held until init or reset.
REQ-013 The block SHALL have port fail_count  output  FAIL_CNT_WIDTH  saturating count of mismatches since reset.

Function
REQ-014 The block SHALL implement the states IDLE, LOAD, COMPARE and DONE.
REQ-015 init SHALL move the block from any state to LOAD, and SHALL clear the load mask, the calc-captured flag, the diff accumulator and tag_correct.
REQ-016 In LOAD, exp_we SHALL store exp_data into word exp_addr and set that word's mask bit; rewriting a word overwrites it.
REQ-017 In LOAD, calc_tag_valid SHALL capture calc_tag and set calc-captured; a later strobe in LOAD recaptures.
REQ-018 The block SHALL go LOAD->COMPARE on the cycle after the mask is 4'hF and calc-captured is set, in either order of arrival.
REQ-019 COMPARE SHALL last exactly 4 cycles, cycle i ORing (exp word i XOR calc word i) into the 32-bit diff accumulator, with no early exit on mismatch (constant time).
REQ-020 After COMPARE the block SHALL enter DONE for one cycle, asserting done, setting tag_correct = (diff == 0) and incrementing fail_count on mismatch, saturating at all-ones.
REQ-021 DONE SHALL go to IDLE unconditionally.
REQ-022 Outside LOAD, exp_we and calc_tag_valid SHALL be ignored.
REQ-023 init in the same cycle as exp_we or calc_tag_valid SHALL win; the write or capture is discarded.
REQ-024 init during COMPARE SHALL abort the comparison, with no done pulse and no change to fail_count.
REQ-025 From the cycle both inputs are present to the done pulse the latency SHALL be 6 cycles (1 transition + 4 compare + DONE), independent of data.

Reset
REQ-026 reset_n low SHALL asynchronously force state IDLE, ready=1, done=0, tag_correct=0, fail_count=0, mask=0, calc-captured=0, diff=0, and clear the expected-tag and calc-tag registers.
REQ-027 Reset mid-operation SHALL discard all partial loads and comparison state.

Structure
REQ-028 The state encodings and the constant TAG_WORDS=4 SHALL live in shared package chacha20_poly1305_pkg.
REQ-029 The block SHALL be a single module with no sub-modules; the comparator is inline datapath.

Verification
REQ-030 Match: init; write words 0..3 = d0600691, 7e902ecb, 4f09e26a, 1ae10b59; calc_tag=1ae10b594f09e26a7e902ecbd0600691 -> done 6 cycles later, tag_correct=1, fail_count=0.
REQ-031 Single-bit mismatch: same as REQ-030 with calc_tag bit 0 flipped -> tag_correct=0, fail_count=1, done at the identical cycle offset as REQ-030.
REQ-032 Order and overwrite: calc_tag before the words, word 2 first written 0 then 4f09e26a -> tag_correct=1.
REQ-033 Abort: init issued during COMPARE cycle 2 -> no done pulse, fail_count unchanged, state LOAD, mask 0.
REQ-034 Saturation: with FAIL_CNT_WIDTH=2, four mismatching runs -> fail_count sequence 1,2,3,3.
REQ-035 Async reset: reset_n low mid-LOAD, between clock edges -> ready=1 and tag_correct=0 immediately, without waiting for a clock edge.
